// File: rtl/hamming_15_11_pkg.sv
// Shared Hamming(15,11) definitions used by both the encoder and the decoder.
// Codeword bit i holds Hamming position i+1. Parity sits at bits 0,1,3,7.
package hamming_15_11_pkg;

  localparam int CW_W   = 15;
  localparam int DATA_W = 11;
  localparam int SYN_W  = 4;

  // Codeword bit indices carrying D1..D11, in order (D1 lands in data[10])
  localparam int DATA_POS [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};

  // Even-parity coverage masks for s1, s2, s4 and s8
  localparam logic [CW_W-1:0] MASK_S1 = 15'h5555;
  localparam logic [CW_W-1:0] MASK_S2 = 15'h6666;
  localparam logic [CW_W-1:0] MASK_S4 = 15'h7878;
  localparam logic [CW_W-1:0] MASK_S8 = 15'h7F80;

  // Everything the second pipeline stage presents to the consumer
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SYN_W-1:0]  syndrome;
    logic              errCorrected;
    logic              errInParity;
  } dec_result_t;

  // Pull the eleven data bits out of a codeword, D1 in the MSB
  function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int k = 0; k < DATA_W; k++) begin
      d[DATA_W-1-k] = cw[DATA_POS[k]];
    end
    return d;
  endfunction

  // Invert the bit named by a non-zero syndrome; a zero syndrome leaves the word alone
  function automatic logic [CW_W-1:0] correct_word(input logic [CW_W-1:0]  cw,
                                                   input logic [SYN_W-1:0] syn);
    logic [CW_W-1:0] flipMask;
    flipMask = '0;
    if (syn != '0) begin
      flipMask = CW_W'(1) << (syn - SYN_W'(1));
    end
    return cw ^ flipMask;
  endfunction

endpackage

// File: rtl/hamming_syndrome_15_11.sv
// Combinational Hamming(15,11) syndrome generator, {s8,s4,s2,s1}.
// A non-zero result is the 1-based position of a single flipped bit.
module hamming_syndrome_15_11
  import hamming_15_11_pkg::*;
(
  input  logic [CW_W-1:0]  codeword_i,
  output logic [SYN_W-1:0] syndrome_o
);

  assign syndrome_o = {^(codeword_i & MASK_S8),
                       ^(codeword_i & MASK_S4),
                       ^(codeword_i & MASK_S2),
                       ^(codeword_i & MASK_S1)};

endmodule

// File: rtl/hamming_decoder_15_11_stream.sv
// Two-stage streaming Hamming(15,11) SEC decoder with valid/ready flow control.
// S1 captures the codeword and its syndrome; S2 holds the corrected result.
// Double errors are miscorrected silently, which is inherent to SEC-only codes.
module hamming_decoder_15_11_stream
  import hamming_15_11_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   codeword_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [SYN_W-1:0]  syndrome_out,
  output logic              err_corrected,
  output logic              err_in_parity,
  input  logic              clear_counts,
  output logic [CNT_W-1:0]  word_count,
  output logic [CNT_W-1:0]  corrected_count
);

  logic              s1Valid_q;
  logic [CW_W-1:0]   s1Cw_q;
  logic [SYN_W-1:0]  s1Syn_q;
  logic              s2Valid_q;
  dec_result_t       s2Res_q;
  dec_result_t       s2Res_d;
  logic [CNT_W-1:0]  wordCnt_q;
  logic [CNT_W-1:0]  wordCnt_d;
  logic [CNT_W-1:0]  corrCnt_q;
  logic [CNT_W-1:0]  corrCnt_d;
  logic [SYN_W-1:0]  inSyn;
  logic              s1Load;
  logic              s2Load;
  logic              outXfer;

  hamming_syndrome_15_11 u_syndrome (
    .codeword_i (codeword_in),
    .syndrome_o (inSyn)
  );

  // S2 frees up whenever the consumer takes its word; S1 frees up when S2 advances
  assign s2Load   = !s2Valid_q || out_ready;
  assign s1Load   = !s1Valid_q || s2Load;
  assign in_ready = s1Load;
  assign outXfer  = s2Valid_q && out_ready;

  // Stage 1: capture the incoming codeword and its syndrome on an input transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1Cw_q    <= '0;
      s1Syn_q   <= '0;
    end else if (s1Load) begin
      s1Valid_q <= in_valid;
      if (in_valid) begin
        s1Cw_q  <= codeword_in;
        s1Syn_q <= inSyn;
      end
    end
  end

  // Correct the stage-1 word and derive its status flags
  always_comb begin
    s2Res_d              = '0;
    s2Res_d.data         = extract_data(correct_word(s1Cw_q, s1Syn_q));
    s2Res_d.syndrome     = s1Syn_q;
    s2Res_d.errCorrected = (s1Syn_q != '0);
    s2Res_d.errInParity  = (s1Syn_q != '0) && ((s1Syn_q & (s1Syn_q - SYN_W'(1))) == '0);
  end

  // Stage 2: result registers only change when a real word moves in, so held outputs stay put
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Valid_q <= 1'b0;
      s2Res_q   <= '0;
    end else if (s2Load) begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        s2Res_q <= s2Res_d;
      end
    end
  end

  // Saturating statistics; a clear wins over a same-cycle increment
  always_comb begin
    wordCnt_d = wordCnt_q;
    corrCnt_d = corrCnt_q;
    if (clear_counts) begin
      wordCnt_d = '0;
      corrCnt_d = '0;
    end else if (outXfer) begin
      if (wordCnt_q != '1) begin
        wordCnt_d = wordCnt_q + CNT_W'(1);
      end
      if (s2Res_q.errCorrected && (corrCnt_q != '1)) begin
        corrCnt_d = corrCnt_q + CNT_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wordCnt_q <= '0;
      corrCnt_q <= '0;
    end else begin
      wordCnt_q <= wordCnt_d;
      corrCnt_q <= corrCnt_d;
    end
  end

  assign out_valid       = s2Valid_q;
  assign data_out        = s2Res_q.data;
  assign syndrome_out    = s2Res_q.syndrome;
  assign err_corrected   = s2Res_q.errCorrected;
  assign err_in_parity   = s2Res_q.errInParity;
  assign word_count      = wordCnt_q;
  assign corrected_count = corrCnt_q;

endmodule

// File: tb/tb_hamming_decoder_15_11_stream.sv
// Self-checking bench for the streaming Hamming(15,11) decoder.
// Expected results come from a position-XOR Hamming model and a scoreboard queue.
module tb_hamming_decoder_15_11_stream;

  typedef struct {
    logic [10:0] data;
    logic [3:0]  syn;
    logic        errc;
    logic        errp;
  } result_t;

  typedef struct {
    result_t r;
    int      acceptCycle;
    bit      checkLat;
  } sbEntry_t;

  typedef struct {
    logic [14:0] cw;
    result_t     exp;
  } vector_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] codeword_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [10:0] data_out;
  logic [3:0]  syndrome_out;
  logic        err_corrected;
  logic        err_in_parity;
  logic        clear_counts = 1'b0;
  logic [3:0]  word_count;
  logic [3:0]  corrected_count;

  int          checkCount = 0;
  int          failCount = 0;
  int          cycleCnt = 0;
  sbEntry_t    expQ[$];
  bit          latCheckOn = 1'b0;
  int          modelWord = 0;
  int          modelCorr = 0;
  bit          prevHeld = 1'b0;
  logic [10:0] prevData;
  logic [3:0]  prevSyn;
  logic        prevErrc;
  logic        prevErrp;
  sbEntry_t    curEntry;
  bit          xferErrc;
  bit          sendsDone;
  vector_t     vecs[6];

  hamming_decoder_15_11_stream #(.CNT_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .codeword_in     (codeword_in),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .data_out        (data_out),
    .syndrome_out    (syndrome_out),
    .err_corrected   (err_corrected),
    .err_in_parity   (err_in_parity),
    .clear_counts    (clear_counts),
    .word_count      (word_count),
    .corrected_count (corrected_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  function automatic bit isPow2(input int v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Reference decode: syndrome is the XOR of the 1-based positions of every set bit
  function automatic result_t refDecode(input logic [14:0] cw);
    result_t     r;
    int          syn;
    int          k;
    logic [14:0] fixed;
    syn = 0;
    for (int i = 0; i < 15; i++) if (cw[i]) syn ^= (i + 1);
    fixed = cw;
    if (syn != 0) fixed[syn-1] = ~fixed[syn-1];
    r.data = '0;
    k = 0;
    for (int pos = 1; pos <= 15; pos++) begin
      if (!isPow2(pos)) begin
        r.data[10-k] = fixed[pos-1];
        k++;
      end
    end
    r.syn  = 4'(syn);
    r.errc = (syn != 0);
    r.errp = isPow2(syn);
    return r;
  endfunction

  // Build a clean codeword by placing data bits and fixing parity so positions XOR to zero
  function automatic logic [14:0] encodeWord(input logic [10:0] d);
    logic [14:0] cw;
    int          k;
    int          syn;
    cw = '0;
    k = 0;
    syn = 0;
    for (int pos = 1; pos <= 15; pos++) begin
      if (!isPow2(pos)) begin
        cw[pos-1] = d[10-k];
        if (d[10-k]) syn ^= pos;
        k++;
      end
    end
    for (int b = 0; b < 4; b++) if (syn[b]) cw[(1 << b) - 1] = 1'b1;
    return cw;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drive one word and wait (bounded) for acceptance; pushes its expected result on transfer
  task automatic applyStimulus(input logic [14:0] cw, input result_t exp);
    int waited;
    waited = 0;
    codeword_in = cw;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      expQ.push_back('{r: exp, acceptCycle: cycleCnt, checkLat: latCheckOn});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((expQ.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: scoreboard compare, hold stability, latency and counter model
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      modelWord = 0;
      modelCorr = 0;
      prevHeld  = 1'b0;
    end else begin
      if (prevHeld) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_data", 32'(data_out), 32'(prevData));
        checkOutput("hold_syndrome", 32'(syndrome_out), 32'(prevSyn));
        checkOutput("hold_errc", 32'(err_corrected), 32'(prevErrc));
        checkOutput("hold_errp", 32'(err_in_parity), 32'(prevErrp));
      end
      xferErrc = 1'b0;
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkCount++;
          failCount++;
          $display("[TB] FAIL unexpected_output: got data %0h with no word pending", data_out);
        end else begin
          curEntry = expQ.pop_front();
          checkOutput("data_out", 32'(data_out), 32'(curEntry.r.data));
          checkOutput("syndrome_out", 32'(syndrome_out), 32'(curEntry.r.syn));
          checkOutput("err_corrected", 32'(err_corrected), 32'(curEntry.r.errc));
          checkOutput("err_in_parity", 32'(err_in_parity), 32'(curEntry.r.errp));
          if (curEntry.checkLat) checkOutput("latency", 32'(cycleCnt - curEntry.acceptCycle), 32'd2);
          xferErrc = curEntry.r.errc;
        end
      end
      checkOutput("word_count", 32'(word_count), 32'(modelWord));
      checkOutput("corrected_count", 32'(corrected_count), 32'(modelCorr));
      if (clear_counts) begin
        modelWord = 0;
        modelCorr = 0;
      end else if (out_valid && out_ready) begin
        if (modelWord < 15) modelWord++;
        if (xferErrc && modelCorr < 15) modelCorr++;
      end
      prevHeld = out_valid && !out_ready;
      prevData = data_out;
      prevSyn  = syndrome_out;
      prevErrc = err_corrected;
      prevErrp = err_in_parity;
    end
  end

  initial begin
    logic [14:0] cw;
    logic [10:0] d;
    int          mode;
    int          b1;
    int          b2;
    int          waited;

    vecs[0] = '{15'h0000, '{11'h000, 4'h0, 1'b0, 1'b0}};
    vecs[1] = '{15'h7FFF, '{11'h7FF, 4'h0, 1'b0, 1'b0}};
    vecs[2] = '{15'h0007, '{11'h400, 4'h0, 1'b0, 1'b0}};
    vecs[3] = '{15'h0020, '{11'h000, 4'h6, 1'b1, 1'b0}};
    vecs[4] = '{15'h0005, '{11'h400, 4'h2, 1'b1, 1'b1}};
    vecs[5] = '{15'h0080, '{11'h000, 4'h8, 1'b1, 1'b1}};

    // Reset state
    #12;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data_out", 32'(data_out), 32'd0);
    checkOutput("rst_syndrome", 32'(syndrome_out), 32'd0);
    checkOutput("rst_errc", 32'(err_corrected), 32'd0);
    checkOutput("rst_errp", 32'(err_in_parity), 32'd0);
    checkOutput("rst_word_count", 32'(word_count), 32'd0);
    checkOutput("rst_corr_count", 32'(corrected_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table, back-to-back with out_ready high and two-cycle latency
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    latCheckOn = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(vecs[i].cw, vecs[i].exp);
    latCheckOn = 1'b0;
    waitDrain();

    // Backpressure: five words with the consumer stalled
    out_ready = 1'b0;
    applyStimulus(encodeWord(11'h123), refDecode(encodeWord(11'h123)));
    applyStimulus(encodeWord(11'h456), refDecode(encodeWord(11'h456)));
    codeword_in = encodeWord(11'h789);
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
    fork
      begin
        applyStimulus(encodeWord(11'h789), refDecode(encodeWord(11'h789)));
        applyStimulus(encodeWord(11'h2AB), refDecode(encodeWord(11'h2AB)));
        applyStimulus(encodeWord(11'h5CD), refDecode(encodeWord(11'h5CD)));
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain();

    // Randomized traffic with random backpressure and 0/1/2-bit corruption
    sendsDone = 1'b0;
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          d = 11'($urandom);
          cw = encodeWord(d);
          mode = $urandom_range(0, 2);
          b1 = $urandom_range(0, 14);
          b2 = (b1 + $urandom_range(1, 14)) % 15;
          if (mode >= 1) cw[b1] = ~cw[b1];
          if (mode == 2) cw[b2] = ~cw[b2];
          applyStimulus(cw, refDecode(cw));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        sendsDone = 1'b1;
      end
      begin
        while (!sendsDone) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    waitDrain();

    // Counter saturation with CNT_W=4
    clear_counts = 1'b1;
    @(posedge clk);
    #1;
    clear_counts = 1'b0;
    @(negedge clk);
    checkOutput("clear_word_count", 32'(word_count), 32'd0);
    checkOutput("clear_corr_count", 32'(corrected_count), 32'd0);
    @(posedge clk);
    #1;
    for (int n = 0; n < 20; n++) begin
      cw = encodeWord(11'($urandom));
      b1 = $urandom_range(0, 14);
      cw[b1] = ~cw[b1];
      applyStimulus(cw, refDecode(cw));
    end
    waitDrain();
    @(negedge clk);
    checkOutput("sat_word_count", 32'(word_count), 32'hF);
    checkOutput("sat_corr_count", 32'(corrected_count), 32'hF);

    // Reset mid-stream with both stages full
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(encodeWord(11'h0F0), refDecode(encodeWord(11'h0F0)));
    applyStimulus(encodeWord(11'h70F), refDecode(encodeWord(11'h70F)));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_word_count", 32'(word_count), 32'd0);
    checkOutput("midrst_corr_count", 32'(corrected_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    cw = encodeWord(11'h3C5);
    cw[9] = ~cw[9];
    applyStimulus(cw, '{11'h3C5, 4'hA, 1'b1, 1'b0});
    waitDrain();

    // Clear in the same cycle as an output transfer
    out_ready = 1'b0;
    applyStimulus(encodeWord(11'h111), refDecode(encodeWord(11'h111)));
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("clrx_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    clear_counts = 1'b1;
    @(posedge clk);
    #1;
    clear_counts = 1'b0;
    @(negedge clk);
    checkOutput("clrx_word_count", 32'(word_count), 32'd0);
    checkOutput("clrx_corr_count", 32'(corrected_count), 32'd0);
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
